// File: rtl/prod_accum.sv
// prod_accum: accumulates LEN unsigned 6-bit products into a 10-bit window
// total and hands the result downstream with a valid/ready handshake.
//
// Build option: define PROD_ACCUM_SAT_EN to saturate the window total at
// 1023 and raise ovf; without it the total wraps modulo 1024 and ovf is 0.
//
// The window counter is kept one bit wider than the cnt port so that a
// window of 32 can be detected; cnt shows the low 5 bits of that count.
module prod_accum #(
   parameter int LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [5:0] p,
   input  logic       p_valid,
   output logic       p_ready,
   output logic [9:0] sum,
   output logic       ovf,
   output logic [4:0] cnt,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

`ifdef PROD_ACCUM_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [5:0] LEN_C = 6'(LEN);

   state_t     state_q, state_d;
   logic [9:0] acc_q,   acc_d;
   logic [5:0] cnt_q,   cnt_d;
   logic       ovf_q,   ovf_d;

   // Full-precision sum: bit 10 is the carry out of the 10-bit accumulator.
   function automatic logic [10:0] add_prod(input logic [9:0] a, input logic [5:0] b);
      return {1'b0, a} + {5'b0, b};
   endfunction

   // Reduce the 11-bit sum to 10 bits: clamp when saturation is enabled, wrap otherwise.
   function automatic logic [9:0] sat_or_wrap(input logic [10:0] s);
      if (SAT_EN && s[10]) begin
         return 10'h3FF;
      end
      return s[9:0];
   endfunction

   logic [10:0] add_full;
   logic [5:0]  cnt_inc;

   assign add_full = add_prod(acc_q, p);
   assign cnt_inc  = cnt_q + 6'd1;

   // Next-state and datapath update; clr beats the output handshake, which beats a product accept.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clr) begin
         state_d = ACC;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACC: begin
               if (p_valid) begin
                  acc_d = sat_or_wrap(add_full);
                  ovf_d = SAT_EN & (ovf_q | add_full[10]);
                  cnt_d = cnt_inc;
                  if (cnt_inc == LEN_C) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               // A product cannot be taken here; the next window starts a cycle after the handshake.
               if (out_ready) begin
                  state_d = ACC;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = ACC;
            end
         endcase
      end
   end

   // State and window registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign p_ready   = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign sum       = acc_q;
   assign cnt       = cnt_q[4:0];
   assign ovf       = SAT_EN ? ovf_q : 1'b0;

endmodule
